serial_sub_reg: RTL and testbench
=================================

# serial_sub_reg

Bit-serial, registered two's-complement subtractor that computes `ain - bin` one bit per cycle, LSB first, through a single full-adder cell. It trades latency for area against the team's registered ripple-carry adder. It sits in the same datapath family and is used where operands arrive occasionally and a start/done handshake is acceptable. Operands are captured on `start`; the result and borrow are registered and held until the next completion.

## Interface
- `WIDTH`, default 4: operand/result width in bits (≥2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only when the block is ready (IDLE or DONE).
- `ain`  in  WIDTH  minuend; captured on the accepting edge.
- `bin`  in  WIDTH  subtrahend; captured on the accepting edge.
- `diff_out`  out  WIDTH  registered `ain - bin` mod 2^WIDTH.
- `borrow_out`  out  1  registered borrow: 1 iff `ain < bin` (unsigned).
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; `diff_out`/`borrow_out` are valid from this cycle.

## Operation
- Arithmetic: `ain + ~bin + 1`, serially. The carry flop is initialised to 1 on accept. Each SHIFT cycle:
  - `s = a[0] ^ ~b[0] ^ c`;
  - `c <= majority(a[0], ~b[0], c)`;
  - `a`/`b` shift right;
  - `s` enters the result shift register at the MSB.
- `borrow_out = ~c_final`. Operands are treated as unsigned; no signed overflow flag.
- FSM states and transitions:
  - IDLE: `start=1` → SHIFT (latch operands, carry←1, bit counter←0); otherwise stay.
  - SHIFT: counter increments each cycle; at counter `== WIDTH-1` → DONE, and the final result plus borrow are loaded into `diff_out`/`borrow_out` on that edge.
  - DONE: lasts exactly one cycle, with `done=1`. `start=1` → SHIFT (back-to-back, same actions as the IDLE accept); otherwise → IDLE.
- `start` while in SHIFT is ignored: no queueing, no effect on the operation in progress.
- Operand inputs are don't-care except on the accepting edge.
- `diff_out`/`borrow_out` change only on a completion edge (or reset); they hold through subsequent operations until the next completion.
- `busy` and `done` are decoded from registered state: `busy = (state==SHIFT)`, `done = (state==DONE)`.
- Reset (`rst_n=0`, any time, including mid-SHIFT) immediately forces:
  - state to IDLE;
  - `diff_out=0`, `borrow_out=0`, `busy=0`, `done=0`;
  - internal operand, result and carry registers to 0 (carry to 0).
- A partial result from an aborted operation is never presented.
- On release of `rst_n`, the first `start` is accepted on the first rising edge where `rst_n=1`.

## Timing
- Accept at edge E0 → `busy=1` for cycles following E0 … E(WIDTH-1) → result registered at edge E(WIDTH) → `done=1` for exactly one cycle after E(WIDTH).
- Latency from accept edge to `done` is WIDTH cycles. For WIDTH=4, `done` is seen 4 cycles after the accept edge.
- Throughput with `start` held high continuously: one result per WIDTH+1 cycles; the DONE cycle doubles as the next accept.
- No combinational path from inputs to outputs.

## Structure
- Shared package: FSM state enum (IDLE, SHIFT, DONE; 2-bit encoding) and a `clog2`-based counter-width function.
- One natural sub-module: `fa_bit`, a 1-bit combinational full adder (a, b, cin → s, cout). It is instantiated once with `~b[0]` on its b input.
- Everything else (FSM, counter, shift registers, output registers) lives in the top module.

## Test plan
- Reset then idle: `rst_n` low for 2 cycles, then high with `start=0` for 10 cycles → all outputs 0; `busy` and `done` never assert.
- Basic, WIDTH=4: `ain=9`, `bin=3`, `start` pulsed → `busy` high for 4 cycles, then `done` pulse with `diff_out=4'h6`, `borrow_out=0`.
- Borrow and wrap: 3−9 → `diff_out=4'hA`, `borrow_out=1`; 0−1 → `4'hF`, `borrow_out=1`; 0−0 → `4'h0`, `borrow_out=0`; 15−15 → `4'h0`, `borrow_out=0`.
- `start` during busy: accept 9−3, then pulse `start` with `ain=1`, `bin=2` in the second SHIFT cycle → single `done` with 6/0; no second operation follows.
- Back-to-back: hold `start=1`, presenting 5−2 then 2−5 in the DONE cycle → results 3/0, then `4'hD`/1. `done` pulses are 5 cycles apart; `diff_out` holds 3 until the second completion.
- Reset mid-operation: accept 12−4, drop `rst_n` on the 2nd SHIFT cycle → outputs immediately 0. After release, no `done` appears until a new `start`; then 7−7 → 0/0.

Source files
------------

// File: rtl/serial_sub_reg_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bit counter only has to reach WIDTH-1; keep at least one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_sub_reg_fa_bit.sv
// One-bit combinational full adder; the single arithmetic cell of the subtractor.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub_reg.sv
// Bit-serial ain - bin (LSB first) through one full adder, with start/done handshake
// and registered result/borrow held until the next completion.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; result registers hold last completion
// ST_SHIFT | one operand bit per cycle through the adder, counter 0..WIDTH-1
// ST_DONE  | one-cycle done pulse; start here re-accepts immediately
module serial_sub_reg
    import serial_sub_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              c_q, c_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;

    logic              sum_bit;
    logic              carry_out;
    logic [WIDTH-1:0]  res_shifted;
    logic              accept;

    // Subtraction as ain + ~bin + 1: inverted subtrahend bit, carry seeded to 1.
    fa_bit u_fa (
        .a    (a_q[0]),
        .b    (~b_q[0]),
        .cin  (c_q),
        .s    (sum_bit),
        .cout (carry_out)
    );

    assign res_shifted = {sum_bit, res_q[WIDTH-1:1]};
    assign accept      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        c_d      = c_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    a_d     = ain;
                    b_d     = bin;
                    c_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shifted;
                c_d   = carry_out;
                cnt_d = cnt_q + CW'(1);
                // Final bit: publish result from the shifter's next value, not res_q.
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    diff_d   = res_shifted;
                    borrow_d = ~carry_out;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            c_q      <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            c_q      <= c_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;
    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_sub_reg.sv
// Self-checking bench for serial_sub_reg (WIDTH=4) against an arithmetic reference model.
module tb_serial_sub_reg;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] ain;
    logic [W-1:0] bin;
    logic [W-1:0] diff_out;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    serial_sub_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ain        (ain),
        .bin        (bin),
        .diff_out   (diff_out),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_diff(input int a, input int b);
        int r;
        r = (a - b + (1 << W)) % (1 << W);
        return W'(r);
    endfunction

    function automatic logic model_borrow(input int a, input int b);
        return (a < b);
    endfunction

    // Pulse start with the operands, then wait (bounded) for done.
    // lat counts negedge samples with done low after the accepting edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_n, output logic held,
                          output logic [W-1:0] d, output logic br);
        logic [W-1:0] prev;
        @(negedge clk);
        prev  = diff_out;
        start = 1'b1;
        ain   = a;
        bin   = b;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        ain    = W'($urandom);
        bin    = W'($urandom);
        lat    = 0;
        busy_n = 0;
        held   = 1'b1;
        while (!done && lat < 20) begin
            if (busy) busy_n++;
            if (diff_out !== prev) held = 1'b0;
            lat++;
            @(negedge clk);
        end
        d  = diff_out;
        br = borrow_out;
    endtask

    task automatic test_reset();
        logic bad;
        rst_n = 1'b0;
        start = 1'b0;
        ain   = '0;
        bin   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({diff_out, borrow_out, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got diff=%h borrow=%b busy=%b done=%b want all 0",
                     diff_out, borrow_out, busy, done);
        end
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if ({diff_out, borrow_out, busy, done} !== '0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: outputs nonzero while idle, got bad=%b want 0", bad);
        end
    endtask

    task automatic test_basic();
        int lat, bn;
        logic held, br;
        logic [W-1:0] d;
        run_op(4'd9, 4'd3, lat, bn, held, d, br);
        checks++;
        if (bn !== 4) begin
            errors++;
            $display("FAIL basic_busy: got %0d busy cycles want 4", bn);
        end
        checks++;
        if (lat !== 4 || done !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: got lat=%0d done=%b want lat=4 done=1", lat, done);
        end
        checks++;
        if (d !== 4'h6 || br !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %h/%b want 6/0", d, br);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b one cycle later want 0", done);
        end
    endtask

    task automatic test_borrow_wrap();
        int a_t[4] = '{3, 0, 0, 15};
        int b_t[4] = '{9, 1, 0, 15};
        logic [W-1:0] d_t[4] = '{4'hA, 4'hF, 4'h0, 4'h0};
        logic br_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat, bn;
        logic held, br;
        logic [W-1:0] d;
        for (int i = 0; i < 4; i++) begin
            run_op(W'(a_t[i]), W'(b_t[i]), lat, bn, held, d, br);
            checks++;
            if (d !== d_t[i] || br !== br_t[i] || done !== 1'b1) begin
                errors++;
                $display("FAIL borrow_wrap %0d-%0d: got %h/%b done=%b want %h/%b done=1",
                         a_t[i], b_t[i], d, br, done, d_t[i], br_t[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, bn, a, b;
        logic held, br;
        logic [W-1:0] d;
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            b = int'($urandom_range(0, (1 << W) - 1));
            run_op(W'(a), W'(b), lat, bn, held, d, br);
            checks++;
            if (d !== model_diff(a, b) || br !== model_borrow(a, b) || lat !== W || bn !== W) begin
                errors++;
                $display("FAIL random %0d-%0d: got %h/%b lat=%0d busy=%0d want %h/%b lat=%0d busy=%0d",
                         a, b, d, br, lat, bn, model_diff(a, b), model_borrow(a, b), W, W);
            end
            checks++;
            if (held !== 1'b1) begin
                errors++;
                $display("FAIL random_hold %0d-%0d: diff_out changed before done, got held=%b want 1",
                         a, b, held);
            end
        end
    endtask

    task automatic test_start_during_busy();
        int n, dones, busies;
        @(negedge clk);
        start = 1'b1;
        ain   = 4'd9;
        bin   = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ain   = W'($urandom);
        bin   = W'($urandom);
        @(negedge clk);
        start = 1'b1;
        ain   = 4'd1;
        bin   = 4'd2;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || diff_out !== 4'h6 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_result: got done=%b %h/%b want done=1 6/0",
                     done, diff_out, borrow_out);
        end
        dones = 0;
        busies = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busies++;
        end
        checks++;
        if (dones !== 0 || busies !== 0 || diff_out !== 4'h6) begin
            errors++;
            $display("FAIL busy_start_ignored: got dones=%0d busy=%0d diff=%h want 0/0/6",
                     dones, busies, diff_out);
        end
    endtask

    task automatic test_back_to_back();
        int n, gap;
        logic held;
        @(negedge clk);
        start = 1'b1;
        ain   = 4'd5;
        bin   = 4'd2;
        @(posedge clk);
        @(negedge clk);
        ain = W'($urandom);
        bin = W'($urandom);
        n = 0;
        while (!done && n < 20) begin
            n++;
            @(negedge clk);
            if (!done) begin
                ain = W'($urandom);
                bin = W'($urandom);
            end
        end
        checks++;
        if (done !== 1'b1 || diff_out !== 4'h3 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got done=%b %h/%b want done=1 3/0", done, diff_out, borrow_out);
        end
        ain = 4'd2;
        bin = 4'd5;
        @(negedge clk);
        start = 1'b0;
        ain   = W'($urandom);
        bin   = W'($urandom);
        gap  = 1;
        held = 1'b1;
        while (!done && gap < 20) begin
            if (diff_out !== 4'h3) held = 1'b0;
            gap++;
            @(negedge clk);
        end
        checks++;
        if (gap !== 5) begin
            errors++;
            $display("FAIL b2b_spacing: got done gap %0d want 5", gap);
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold: diff_out left 3 before second done, got held=%b want 1", held);
        end
        checks++;
        if (done !== 1'b1 || diff_out !== 4'hD || borrow_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got done=%b %h/%b want done=1 d/1", done, diff_out, borrow_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int lat, bn, dones;
        logic held, br;
        logic [W-1:0] d;
        @(negedge clk);
        start = 1'b1;
        ain   = 4'd12;
        bin   = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({diff_out, borrow_out, busy, done} !== '0) begin
            errors++;
            $display("FAIL midop_reset: got diff=%h borrow=%b busy=%b done=%b want all 0",
                     diff_out, borrow_out, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy || diff_out !== '0) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midop_quiet: got %0d active/nonzero cycles after release want 0", dones);
        end
        run_op(4'd7, 4'd7, lat, bn, held, d, br);
        checks++;
        if (d !== 4'h0 || br !== 1'b0 || done !== 1'b1 || lat !== 4) begin
            errors++;
            $display("FAIL midop_after: got %h/%b done=%b lat=%0d want 0/0 done=1 lat=4",
                     d, br, done, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_wrap();
        test_random();
        test_start_during_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
